// File: rtl/burst_uart_frame_buf.sv
// -----------------------------------------------------------------------------
// burst_uart_frame_buf
//
// Captures one block of SDRAM read-burst words into an on-chip buffer. When
// uart_oneframe_start is high and the buffer is full, it streams the block to
// the UART transmitter one byte at a time, most significant byte of each word
// first.
//
// Handshake (tx side): a byte moves on every rising mem_clk edge where
// tx_data_valid and tx_data_ready are both high. While tx_data_valid is high
// and tx_data_ready is low, tx_data and tx_data_valid hold their values. The
// transmitter may hold tx_data_ready high or low at any time.
//
// Ports:
//   mem_clk              clock
//   rst                  asynchronous, active-high reset
//   rd_burst_data_valid  write strobe; one word per strobe, gaps allowed
//   rd_burst_data        write word (MEM_DATA_BITS)
//   uart_oneframe_start  level request to send the buffered block
//   uart_oneframe_done   high = idle with empty buffer
//   tx_data              byte to the UART transmitter
//   tx_data_valid        tx_data holds a byte to send
//   tx_data_ready        transmitter accepts tx_data this cycle
//   fill_level           words currently held (0..BLOCK_WORDS)
//   wr_overflow          sticky; a word arrived while the buffer was full
//
// Internal FSM state is held in state_q (type state_t) for observation.
// -----------------------------------------------------------------------------
module burst_uart_frame_buf #(
  parameter int MEM_DATA_BITS = 32,   // multiple of 8
  parameter int BLOCK_WORDS   = 256,  // power of 2
  parameter int PTR_BITS      = 8     // log2(BLOCK_WORDS)
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     uart_oneframe_start,
  output logic                     uart_oneframe_done,
  output logic [7:0]               tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_data_ready,
  output logic [PTR_BITS:0]        fill_level,
  output logic                     wr_overflow
);

  localparam int BYTES_PER_WORD = MEM_DATA_BITS / 8;
  localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [PTR_BITS:0]   FULL_LEVEL = (PTR_BITS+1)'(BLOCK_WORDS);
  localparam logic [PTR_BITS-1:0] LAST_PTR   = PTR_BITS'(BLOCK_WORDS - 1);
  localparam logic [BIDX_W-1:0]   LAST_BYTE  = BIDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Buffer storage (not reset) with a registered read port.
  // ---------------------------------------------------------------------------
  logic [MEM_DATA_BITS-1:0] mem [BLOCK_WORDS];
  logic [MEM_DATA_BITS-1:0] rd_word;

  logic [PTR_BITS-1:0] wr_ptr_q;
  logic [PTR_BITS:0]   fill_q;
  logic                overflow_q;
  logic                done_q;

  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [MEM_DATA_BITS-1:0] shift_q, shift_d;
  logic [MEM_DATA_BITS-1:0] shift_nxt;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  logic full;
  logic wr_en;

  assign full  = (fill_q == FULL_LEVEL);
  // A full buffer refuses words; this also covers the DONE cycle, where the
  // buffer is still full, so a word arriving then is counted as overflow.
  assign wr_en = rd_burst_data_valid && !full;

  always_ff @(posedge mem_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= rd_burst_data;
    end
    rd_word <= mem[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Write side: pointer, fill count, overflow flag and the done level.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b1;
    end else begin
      if (state_q == S_DONE) begin
        // Block fully sent: the buffer becomes empty for the next block.
        wr_ptr_q <= '0;
        fill_q   <= '0;
        done_q   <= 1'b1;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
        fill_q   <= fill_q + (PTR_BITS+1)'(1);
        if (fill_q == '0) begin
          done_q <= 1'b0;
        end
      end
      if (rd_burst_data_valid && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read / transmit FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // The shift register keeps the current byte at the top; shifting left by a
  // byte exposes the next lower byte of the word.
  assign shift_nxt = shift_q << 8;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      S_IDLE: begin
        // A start with a partially filled buffer is ignored.
        if (uart_oneframe_start && full) begin
          rd_ptr_d = '0;
          state_d  = S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        // rd_ptr_q is on the buffer address this cycle.
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        shift_d    = rd_word;
        byte_idx_d = '0;
        tx_data_d  = rd_word[MEM_DATA_BITS-1 -: 8];
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (tx_data_ready) begin
          if (byte_idx_q != LAST_BYTE) begin
            shift_d    = shift_nxt;
            tx_data_d  = shift_nxt[MEM_DATA_BITS-1 -: 8];
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end else begin
            tx_valid_d = 1'b0;
            if (rd_ptr_q == LAST_PTR) begin
              state_d = S_DONE;
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
              state_d  = S_RD_REQ;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign uart_oneframe_done = done_q;
  assign tx_data            = tx_data_q;
  assign tx_data_valid      = tx_valid_q;
  assign fill_level         = fill_q;
  assign wr_overflow        = overflow_q;

endmodule

// File: tb/tb_burst_uart_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_burst_uart_frame_buf
//
// Directed sequence of block transfers. Expected byte streams come from the
// list of words written, split MSB first. A monitor collects every byte that
// crosses the tx handshake and tracks hold-stability while stalled.
// -----------------------------------------------------------------------------
module tb_burst_uart_frame_buf;

  localparam int W    = 32;
  localparam int NW   = 256;
  localparam int PB   = 8;
  localparam int NB   = W / 8;
  localparam int NBYT = NW * NB;

  // clock / reset
  logic mem_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 mem_clk = ~mem_clk;

  logic          rd_burst_data_valid = 1'b0;
  logic [W-1:0]  rd_burst_data       = '0;
  logic          uart_oneframe_start = 1'b0;
  logic          uart_oneframe_done;
  logic [7:0]    tx_data;
  logic          tx_data_valid;
  logic          tx_data_ready = 1'b1;
  logic [PB:0]   fill_level;
  logic          wr_overflow;

  burst_uart_frame_buf #(
    .MEM_DATA_BITS (W),
    .BLOCK_WORDS   (NW),
    .PTR_BITS      (PB)
  ) dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .uart_oneframe_start (uart_oneframe_start),
    .uart_oneframe_done  (uart_oneframe_done),
    .tx_data             (tx_data),
    .tx_data_valid       (tx_data_valid),
    .tx_data_ready       (tx_data_ready),
    .fill_level          (fill_level),
    .wr_overflow         (wr_overflow)
  );

  // scoreboard state
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] words[$];
  logic [7:0]   exp_q[$];
  logic [7:0]   got_q[$];
  bit           ready_rand = 1'b0;

  // transmitter: ready either held high or random per cycle
  always @(posedge mem_clk) begin
    #1;
    tx_data_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: capture handshaken bytes, verify stability while stalled
  int         stab_checks = 0;
  int         stab_viol   = 0;
  bit         pend        = 1'b0;
  logic [7:0] pend_data   = '0;
  always @(negedge mem_clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        stab_checks++;
        if (!(tx_data_valid === 1'b1 && tx_data === pend_data)) stab_viol++;
      end
      if (tx_data_valid === 1'b1 && tx_data_ready === 1'b1) got_q.push_back(tx_data);
      pend      = (tx_data_valid === 1'b1) && (tx_data_ready === 1'b0);
      pend_data = tx_data;
    end
  end

  task automatic wait_clk();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: every word contributes its bytes, most significant first
  task automatic build_exp(input int n_words);
    exp_q.delete();
    for (int i = 0; i < n_words; i++) begin
      for (int k = 0; k < NB; k++) begin
        exp_q.push_back(8'(words[i] >> (8 * (NB - 1 - k))));
      end
    end
  endtask

  task automatic write_words(input int from, input int to, input int gap_max);
    for (int i = from; i <= to; i++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = words[i];
      wait_clk();
      rd_burst_data_valid = 1'b0;
      rd_burst_data       = '0;
      repeat ($urandom_range(0, gap_max)) wait_clk();
    end
  endtask

  // waits for n bytes past base, then for the done level; lag = cycles after
  // the last byte until done is seen
  task automatic wait_block(input string tag, input int base, input int n);
    int cyc;
    int lag;
    cyc = 0;
    while (got_q.size() < base + n && cyc < 20000) begin
      wait_clk();
      cyc++;
    end
    check({tag, "_bytes_timeout"}, 64'(cyc < 20000), 64'd1);
    lag = 0;
    while (uart_oneframe_done !== 1'b1 && lag < 10) begin
      wait_clk();
      lag++;
    end
    check({tag, "_done_lag_ok"}, 64'(lag <= 3), 64'd1);
    check({tag, "_fill_after"}, 64'(fill_level), 64'd0);
  endtask

  task automatic compare_block(input string tag, input int base);
    check({tag, "_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= got_q.size()) break;
      check($sformatf("%s_byte%0d", tag, i), 64'(got_q[base + i]), 64'(exp_q[i]));
      if (got_q[base + i] !== exp_q[i]) break;
    end
  endtask

  initial begin
    int base;
    int cyc;
    bit seen_bad;

    // ---- reset ----
    repeat (3) wait_clk();
    check("rst_done",     64'(uart_oneframe_done), 64'd1);
    check("rst_valid",    64'(tx_data_valid),      64'd0);
    check("rst_fill",     64'(fill_level),         64'd0);
    check("rst_overflow", 64'(wr_overflow),        64'd0);
    check("rst_tx_data",  64'(tx_data),            64'd0);
    rst = 1'b0;
    repeat (2) wait_clk();

    // ---- block 1: counting words, back to back, ready held high ----
    words.delete();
    for (int i = 0; i < NW; i++) words.push_back(W'(i));
    build_exp(NW);
    ready_rand = 1'b0;
    write_words(0, 0, 0);
    check("b1_done_low_after_first", 64'(uart_oneframe_done), 64'd0);
    check("b1_fill_one", 64'(fill_level), 64'd1);
    write_words(1, NW - 1, 0);
    check("b1_fill_full", 64'(fill_level), 64'(NW));
    check("b1_no_overflow", 64'(wr_overflow), 64'd0);
    check("b1_idle_no_valid", 64'(tx_data_valid), 64'd0);
    base = got_q.size();
    uart_oneframe_start = 1'b1;
    wait_block("b1", base, NBYT);
    uart_oneframe_start = 1'b0;
    compare_block("b1", base);
    wait_clk();

    // ---- block 2: same words, random gaps and random ready ----
    ready_rand = 1'b1;
    write_words(0, NW - 1, 5);
    check("b2_fill_full", 64'(fill_level), 64'(NW));
    base = got_q.size();
    uart_oneframe_start = 1'b1;
    wait_block("b2", base, NBYT);
    uart_oneframe_start = 1'b0;
    compare_block("b2", base);
    wait_clk();

    // ---- block 3: start with a partial buffer, random data ----
    words.delete();
    for (int i = 0; i < NW; i++) words.push_back(W'($urandom));
    build_exp(NW);
    base = got_q.size();
    uart_oneframe_start = 1'b1;
    write_words(0, NW - 2, 2);
    repeat (10) wait_clk();
    check("b3_partial_no_valid", 64'(tx_data_valid), 64'd0);
    check("b3_partial_no_bytes", 64'(got_q.size() - base), 64'd0);
    check("b3_partial_fill", 64'(fill_level), 64'(NW - 1));
    rd_burst_data_valid = 1'b1;
    rd_burst_data       = words[NW - 1];
    wait_clk();
    rd_burst_data_valid = 1'b0;
    cyc = 0;
    while (tx_data_valid !== 1'b1 && cyc < 10) begin
      wait_clk();
      cyc++;
    end
    check("b3_start_latency_ok", 64'(cyc <= 3), 64'd1);
    wait_block("b3", base, NBYT);
    uart_oneframe_start = 1'b0;
    compare_block("b3", base);
    wait_clk();

    // ---- block 4: 257 words, the last one must be dropped ----
    words.delete();
    for (int i = 0; i < NW; i++) words.push_back(W'($urandom));
    words.push_back(32'hDEADBEEF);
    build_exp(NW);
    write_words(0, NW, 1);
    check("b4_overflow", 64'(wr_overflow), 64'd1);
    check("b4_fill_full", 64'(fill_level), 64'(NW));
    base = got_q.size();
    uart_oneframe_start = 1'b1;
    wait_block("b4", base, NBYT);
    uart_oneframe_start = 1'b0;
    compare_block("b4", base);
    seen_bad = 1'b0;
    for (int i = base; i + NB <= got_q.size(); i += NB) begin
      if ({got_q[i], got_q[i+1], got_q[i+2], got_q[i+3]} == 32'hDEADBEEF) seen_bad = 1'b1;
    end
    check("b4_dropped_word_absent", 64'(seen_bad), 64'd0);
    check("b4_overflow_sticky", 64'(wr_overflow), 64'd1);
    wait_clk();

    // ---- block 5: reset after 500 bytes, then a fresh block ----
    words.delete();
    for (int i = 0; i < NW; i++) words.push_back(W'($urandom));
    write_words(0, NW - 1, 0);
    base = got_q.size();
    uart_oneframe_start = 1'b1;
    cyc = 0;
    while (got_q.size() < base + 500 && cyc < 20000) begin
      wait_clk();
      cyc++;
    end
    check("b5_reach_500_timeout", 64'(cyc < 20000), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("b5_rst_valid_now", 64'(tx_data_valid),      64'd0);
    check("b5_rst_done_now",  64'(uart_oneframe_done), 64'd1);
    check("b5_rst_fill_now",  64'(fill_level),         64'd0);
    check("b5_rst_overflow",  64'(wr_overflow),        64'd0);
    wait_clk();
    uart_oneframe_start = 1'b0;
    rst = 1'b0;
    repeat (2) wait_clk();
    check("b5_idle_after_rst", 64'(tx_data_valid), 64'd0);

    words.delete();
    for (int i = 0; i < NW; i++) words.push_back(W'($urandom));
    build_exp(NW);
    write_words(0, NW - 1, 3);
    base = got_q.size();
    uart_oneframe_start = 1'b1;
    wait_block("b6", base, NBYT);
    uart_oneframe_start = 1'b0;
    compare_block("b6", base);

    // hold-stability under back-pressure across all blocks
    check("stall_hold_violations", 64'(stab_viol), 64'd0);
    check("stall_seen", 64'(stab_checks > 0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
